// File: rtl/boot_uart_rx.sv
// 8N1 UART receiver feeding the boot-time instruction-memory loader.
// Bit period is latched per frame; bad stop bits raise a framing pulse instead of data.
module boot_uart_rx #(
    parameter int CPB_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CPB_W-1:0] clks_per_bit_i,
    input  logic             rx_i,
    output logic             rx_dv_o,
    output logic [7:0]       rx_byte_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    // state  | meaning
    // IDLE   | line idle, waiting for a low level on rx_s
    // START  | timing to mid start bit to reject glitches
    // DATA   | sampling 8 data bits at mid-bit, LSB first
    // STOP   | sampling the stop bit; good byte or framing error
    // BREAK  | stop bit was low, waiting for the line to go high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q;
    logic             rx_meta;
    logic             rx_s;
    logic [CPB_W-1:0] cnt_q;
    logic [CPB_W-1:0] cpb_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [CPB_W-1:0] half_m1;
    logic [CPB_W-1:0] full_m1;

    assign half_m1 = (cpb_q >> 1) - CPB_W'(1);
    assign full_m1 = cpb_q - CPB_W'(1);
    assign busy_o  = (state_q != S_IDLE);

    // Two-flop synchronizer; reset high so a reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cpb_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_o   <= 8'h00;
            rx_dv_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_dv_o     <= 1'b0;
            frame_err_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q   <= S_START;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        cpb_q     <= clks_per_bit_i;
                    end
                end
                S_START: begin
                    if (cnt_q == half_m1) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CPB_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == full_m1) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CPB_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == full_m1) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            rx_byte_o <= shift_q;
                            rx_dv_o   <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CPB_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_uart_rx.sv
// Directed bench for boot_uart_rx: hand-computed pulse times and bytes per frame.
module tb_boot_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpb_in = 16'd16;
    logic        rx = 1'b1;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        frame_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int both = 0;
    int dv_t[$];
    int dv_b[$];
    int fe_t[$];
    int t0;

    boot_uart_rx #(.CPB_W(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clks_per_bit_i (cpb_in),
        .rx_i           (rx),
        .rx_dv_o        (rx_dv),
        .rx_byte_o      (rx_byte),
        .frame_err_o    (frame_err),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_dv) begin
            dv_t.push_back(cyc);
            dv_b.push_back(int'(rx_byte));
        end
        if (frame_err) fe_t.push_back(cyc);
        if (rx_dv && frame_err) both++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int dv_time(input int i);
        return (i < dv_t.size()) ? dv_t[i] : -1;
    endfunction

    function automatic int dv_byte(input int i);
        return (i < dv_b.size()) ? dv_b[i] : -1;
    endfunction

    function automatic int fe_time(input int i);
        return (i < fe_t.size()) ? fe_t[i] : -1;
    endfunction

    task automatic clear_logs();
        dv_t.delete();
        dv_b.delete();
        fe_t.delete();
    endtask

    // Call just after a rising edge; that edge is edge 0 of the frame.
    task automatic send(input logic [7:0] b, input int cpb, input logic stop_val,
                        input int stop_cycles, output int start_cyc);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (cpb) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
        rx = stop_val;
        repeat (stop_cycles) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dv", int'(rx_dv), 0);
        check("reset_byte", int'(rx_byte), 0);
        check("reset_fe", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        // Single byte 0xA5
        clear_logs();
        send(8'hA5, 16, 1'b1, 16, t0);
        idle(10);
        check("a5_count", dv_t.size(), 1);
        check("a5_time", dv_time(0) - t0, 155);
        check("a5_byte", dv_byte(0), 8'hA5);
        check("a5_fe_count", fe_t.size(), 0);
        check("a5_busy_after", int'(busy), 0);

        // Back-to-back loader word
        clear_logs();
        send(8'h13, 16, 1'b1, 16, t0);
        send(8'h00, 16, 1'b1, 16, t1);
        send(8'h00, 16, 1'b1, 16, t1);
        send(8'h00, 16, 1'b1, 16, t1);
        idle(20);
        check("word_count", dv_t.size(), 4);
        check("word_t0", dv_time(0) - t0, 155);
        check("word_t1", dv_time(1) - t0, 315);
        check("word_t2", dv_time(2) - t0, 475);
        check("word_t3", dv_time(3) - t0, 635);
        check("word_b0", dv_byte(0), 8'h13);
        check("word_b1", dv_byte(1), 8'h00);
        check("word_b2", dv_byte(2), 8'h00);
        check("word_b3", dv_byte(3), 8'h00);
        check("word_hold", int'(rx_byte), 8'h00);
        check("word_fe_count", fe_t.size(), 0);

        // Start glitch: three low cycles
        clear_logs();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_e10", int'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        check("glitch_busy_e11", int'(busy), 0);
        idle(200);
        check("glitch_dv_count", dv_t.size(), 0);
        check("glitch_fe_count", fe_t.size(), 0);
        check("glitch_busy_end", int'(busy), 0);

        // Framing error: stop bit low for 40 cycles
        clear_logs();
        send(8'h5A, 16, 1'b0, 40, t0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("fe_busy_e186", int'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        check("fe_busy_e187", int'(busy), 0);
        idle(10);
        check("fe_count", fe_t.size(), 1);
        check("fe_time", fe_time(0) - t0, 155);
        check("fe_dv_count", dv_t.size(), 0);
        check("fe_byte_hold", int'(rx_byte), 8'h00);

        clear_logs();
        send(8'h3C, 16, 1'b1, 16, t0);
        idle(10);
        check("after_fe_count", dv_t.size(), 1);
        check("after_fe_time", dv_time(0) - t0, 155);
        check("after_fe_byte", dv_byte(0), 8'h3C);

        // Reset in the middle of a 0xFF frame
        clear_logs();
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1 rx = 1'b1;
        repeat (63) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_dv", int'(rx_dv), 0);
        check("midrst_byte", int'(rx_byte), 0);
        check("midrst_fe", int'(frame_err), 0);
        check("midrst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(200);
        check("midrst_dv_count", dv_t.size(), 0);
        check("midrst_fe_count", fe_t.size(), 0);
        send(8'h0F, 16, 1'b1, 16, t0);
        idle(10);
        check("post_rst_count", dv_t.size(), 1);
        check("post_rst_byte", int'(rx_byte), 8'h0F);

        // Divisor change mid-frame; takes effect on the next frame
        clear_logs();
        t1 = cyc;
        fork
            send(8'hC3, 16, 1'b1, 16, t0);
            begin
                repeat (50) @(posedge clk);
                #1 cpb_in = 16'd20;
            end
        join
        idle(10);
        check("cpb_chg_time", dv_time(0) - t0, 155);
        check("cpb_chg_byte", dv_byte(0), 8'hC3);
        send(8'h3A, 20, 1'b1, 20, t0);
        idle(10);
        check("cpb20_count", dv_t.size(), 2);
        check("cpb20_time", dv_time(1) - t0, 193);
        check("cpb20_byte", dv_byte(1), 8'h3A);

        check("dv_fe_overlap", both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
